ex_div_unit: RTL and testbench

//  Multi-cycle signed 32-bit divider for the EX stage of the 5-stage MIPS32 pipeline.

---
 rtl/ex_div_unit_if.sv | 26 ++
 rtl/ex_div_unit.sv | 154 +++++++++++++++
 tb/tb_ex_div_unit.sv | 148 ++++++++++++++
 3 files changed

// File: rtl/ex_div_unit_if.sv
// Handshake and operand/result bundle between the EX-stage control and the divider.
interface ex_div_unit_if #(
  parameter int WIDTH = 32
);
  logic             start_i;
  logic             flush_i;
  logic [WIDTH-1:0] dividend_i;
  logic [WIDTH-1:0] divisor_i;
  logic             busy_o;
  logic             done_o;
  logic [WIDTH-1:0] quotient_o;
  logic [WIDTH-1:0] remainder_o;
  logic             div_zero_o;

  // EX-stage control side
  modport master (
    output start_i, flush_i, dividend_i, divisor_i,
    input  busy_o, done_o, quotient_o, remainder_o, div_zero_o
  );

  // Divider side
  modport slave (
    input  start_i, flush_i, dividend_i, divisor_i,
    output busy_o, done_o, quotient_o, remainder_o, div_zero_o
  );
endinterface

// File: rtl/ex_div_unit.sv
// Multi-cycle signed divider for the EX stage: radix-2 restoring division on
// magnitudes followed by a sign-fix step. Quotient -> LO, remainder -> HI.
//
// state  | meaning
// -------+--------------------------------------------------------------
// S_IDLE | waiting for start; results from the last division held
// S_ITER | one restoring step per cycle, down-counter from WIDTH to 0
// S_SIGN | apply signs to quotient/remainder and register the results
// S_DONE | done_o pulse for one cycle, results valid
module ex_div_unit #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic         clk,
  input  logic         rst,
  ex_div_unit_if.slave div_if
);

  typedef enum logic [1:0] {S_IDLE, S_ITER, S_SIGN, S_DONE} state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic [WIDTH-1:0] quo_q, quo_d;
  logic [WIDTH-1:0] dvsr_q, dvsr_d;
  logic             neg_quo_q, neg_quo_d;
  logic             neg_rem_q, neg_rem_d;
  logic [WIDTH-1:0] quotient_q, quotient_d;
  logic [WIDTH-1:0] remainder_q, remainder_d;
  logic             div_zero_q, div_zero_d;

  logic             accept;
  logic             dvsr_zero;
  logic [WIDTH-1:0] abs_dividend;
  logic [WIDTH-1:0] abs_divisor;
  logic [WIDTH:0]   shifted;
  logic [WIDTH-1:0] diff;
  logic             trial_ge;

  // Magnitudes are kept unsigned in WIDTH bits, so |-2**(WIDTH-1)| is exact.
  assign accept       = (state_q == S_IDLE) & div_if.start_i & ~div_if.flush_i;
  assign dvsr_zero    = (div_if.divisor_i == '0);
  assign abs_dividend = div_if.dividend_i[WIDTH-1] ? (~div_if.dividend_i + 1'b1) : div_if.dividend_i;
  assign abs_divisor  = div_if.divisor_i[WIDTH-1]  ? (~div_if.divisor_i + 1'b1)  : div_if.divisor_i;

  // Partial remainder is always below the divisor, so the shifted value fits
  // in WIDTH+1 bits and a successful trial subtraction fits back into WIDTH.
  assign shifted  = {rem_q, quo_q[WIDTH-1]};
  assign trial_ge = (shifted >= {1'b0, dvsr_q});
  assign diff     = shifted[WIDTH-1:0] - dvsr_q;

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic; flush overrides every busy state
  always_comb begin
    state_d = state_q;
    if (state_q != S_IDLE && div_if.flush_i) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE: if (accept) state_d = dvsr_zero ? S_DONE : S_ITER;
        S_ITER: if (cnt_q == CNT_W'(1)) state_d = S_SIGN;
        S_SIGN: state_d = S_DONE;
        S_DONE: state_d = S_IDLE;
        default: state_d = S_IDLE;
      endcase
    end
  end

  // FSM status outputs
  always_comb begin
    div_if.busy_o = (state_q != S_IDLE);
    div_if.done_o = (state_q == S_DONE);
  end

  assign div_if.quotient_o  = quotient_q;
  assign div_if.remainder_o = remainder_q;
  assign div_if.div_zero_o  = div_zero_q;

  // Datapath next values: operand capture, restoring step, sign fix
  always_comb begin
    cnt_d       = cnt_q;
    rem_d       = rem_q;
    quo_d       = quo_q;
    dvsr_d      = dvsr_q;
    neg_quo_d   = neg_quo_q;
    neg_rem_d   = neg_rem_q;
    quotient_d  = quotient_q;
    remainder_d = remainder_q;
    div_zero_d  = div_zero_q;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          div_zero_d = dvsr_zero;
          if (dvsr_zero) begin
            // Zero divisor short path: results are written straight away.
            quotient_d  = '1;
            remainder_d = div_if.dividend_i;
          end else begin
            quo_d     = abs_dividend;
            dvsr_d    = abs_divisor;
            rem_d     = '0;
            cnt_d     = CNT_W'(WIDTH);
            neg_quo_d = div_if.dividend_i[WIDTH-1] ^ div_if.divisor_i[WIDTH-1];
            neg_rem_d = div_if.dividend_i[WIDTH-1];
          end
        end
      end
      S_ITER: begin
        rem_d = trial_ge ? diff : shifted[WIDTH-1:0];
        quo_d = {quo_q[WIDTH-2:0], trial_ge};
        cnt_d = cnt_q - 1'b1;
      end
      S_SIGN: begin
        // A flush here must leave the previous results untouched.
        if (!div_if.flush_i) begin
          quotient_d  = neg_quo_q ? (~quo_q + 1'b1) : quo_q;
          remainder_d = neg_rem_q ? (~rem_q + 1'b1) : rem_q;
        end
      end
      default: ;
    endcase
  end

  // Datapath registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q       <= '0;
      rem_q       <= '0;
      quo_q       <= '0;
      dvsr_q      <= '0;
      neg_quo_q   <= 1'b0;
      neg_rem_q   <= 1'b0;
      quotient_q  <= '0;
      remainder_q <= '0;
      div_zero_q  <= 1'b0;
    end else begin
      cnt_q       <= cnt_d;
      rem_q       <= rem_d;
      quo_q       <= quo_d;
      dvsr_q      <= dvsr_d;
      neg_quo_q   <= neg_quo_d;
      neg_rem_q   <= neg_rem_d;
      quotient_q  <= quotient_d;
      remainder_q <= remainder_d;
      div_zero_q  <= div_zero_d;
    end
  end

endmodule

// File: tb/tb_ex_div_unit.sv
// Directed bench for ex_div_unit: hand-computed quotient/remainder, latency,
// zero divisor, overflow, flush, mid-operation reset and ignored starts.
module tb_ex_div_unit;

  logic clk;
  logic rst;
  int   n_vec;
  int   n_err;
  int   done_cnt;
  int   lat;
  int   snap;

  ex_div_unit_if #(.WIDTH(32)) div_if ();

  ex_div_unit #(.WIDTH(32), .CNT_W(6)) dut (
    .clk    (clk),
    .rst    (rst),
    .div_if (div_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Count done pulses independently of the directed steps.
  always @(posedge clk) begin
    #1;
    if (div_if.done_o === 1'b1) done_cnt++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Entered at a negedge; returns at the negedge where done_o is seen (or on timeout).
  task automatic run_div(input logic [31:0] a, input logic [31:0] b, input int poke_at,
                         output int lat_o);
    div_if.start_i    = 1'b1;
    div_if.dividend_i = a;
    div_if.divisor_i  = b;
    @(negedge clk);
    div_if.start_i    = 1'b0;
    div_if.dividend_i = 32'h1234_5678;
    div_if.divisor_i  = 32'h0000_0003;
    lat_o = 1;
    while (div_if.done_o !== 1'b1 && lat_o < 60) begin
      div_if.start_i = (lat_o == poke_at);
      @(negedge clk);
      lat_o++;
    end
    div_if.start_i = 1'b0;
  endtask

  task automatic div_test(input string tag, input logic [31:0] a, input logic [31:0] b,
                          input int poke_at, input int exp_lat, input logic [31:0] exp_q,
                          input logic [31:0] exp_r, input logic exp_dz);
    int l;
    run_div(a, b, poke_at, l);
    check({tag, ".lat"},  32'(l), 32'(exp_lat));
    check({tag, ".done"}, {31'd0, div_if.done_o}, 32'd1);
    check({tag, ".q"},    div_if.quotient_o, exp_q);
    check({tag, ".r"},    div_if.remainder_o, exp_r);
    check({tag, ".dz"},   {31'd0, div_if.div_zero_o}, {31'd0, exp_dz});
    // A start during the done cycle is dropped.
    div_if.start_i    = 1'b1;
    div_if.dividend_i = 32'd50;
    div_if.divisor_i  = 32'd5;
    @(negedge clk);
    div_if.start_i = 1'b0;
    check({tag, ".pulse"}, {31'd0, div_if.done_o}, 32'd0);
    check({tag, ".idle"},  {31'd0, div_if.busy_o}, 32'd0);
    check({tag, ".hold"},  div_if.quotient_o, exp_q);
  endtask

  initial begin
    n_vec = 0; n_err = 0; done_cnt = 0;
    rst = 1'b1;
    div_if.start_i = 1'b0; div_if.flush_i = 1'b0;
    div_if.dividend_i = '0; div_if.divisor_i = '0;
    repeat (2) @(negedge clk);
    check("rst.busy", {31'd0, div_if.busy_o}, 32'd0);
    check("rst.done", {31'd0, div_if.done_o}, 32'd0);
    check("rst.q",    div_if.quotient_o, 32'd0);
    check("rst.r",    div_if.remainder_o, 32'd0);
    check("rst.dz",   {31'd0, div_if.div_zero_o}, 32'd0);
    rst = 1'b0;
    @(negedge clk);

    div_test("d100_7",  32'd100,       32'd7,         0, 34, 32'd14,        32'd2,         1'b0);
    div_test("dm7_2",   32'hFFFF_FFF9, 32'd2,         0, 34, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 1'b0);
    div_test("d7_m2",   32'd7,         32'hFFFF_FFFE, 0, 34, 32'hFFFF_FFFD, 32'd1,         1'b0);
    div_test("d5_0",    32'd5,         32'd0,         0, 1,  32'hFFFF_FFFF, 32'd5,         1'b1);
    div_test("ovf",     32'h8000_0000, 32'hFFFF_FFFF, 0, 34, 32'h8000_0000, 32'd0,         1'b0);
    div_test("min_1",   32'h8000_0000, 32'd1,         0, 34, 32'h8000_0000, 32'd0,         1'b0);
    div_test("poke",    32'd100,       32'd7,         5, 34, 32'd14,        32'd2,         1'b0);
    div_test("dm100_m7",32'hFFFF_FF9C, 32'hFFFF_FFF9, 0, 34, 32'd14,        32'hFFFF_FFFE, 1'b0);

    // Flush at cycle 10 of an operation.
    snap = done_cnt;
    div_if.start_i = 1'b1; div_if.dividend_i = 32'd100; div_if.divisor_i = 32'd7;
    @(negedge clk);
    div_if.start_i = 1'b0;
    check("fl.busy_on", {31'd0, div_if.busy_o}, 32'd1);
    repeat (8) @(negedge clk);
    div_if.flush_i = 1'b1;
    @(negedge clk);
    div_if.flush_i = 1'b0;
    check("fl.busy_off", {31'd0, div_if.busy_o}, 32'd0);
    repeat (40) @(negedge clk);
    check("fl.no_done", 32'(done_cnt), 32'(snap));
    check("fl.q",  div_if.quotient_o, 32'd14);
    check("fl.r",  div_if.remainder_o, 32'hFFFF_FFFE);
    check("fl.dz", {31'd0, div_if.div_zero_o}, 32'd0);

    // Flush and start together in idle: start dropped.
    div_if.start_i = 1'b1; div_if.flush_i = 1'b1;
    @(negedge clk);
    div_if.start_i = 1'b0; div_if.flush_i = 1'b0;
    check("flst.busy", {31'd0, div_if.busy_o}, 32'd0);

    div_test("d9_3", 32'd9, 32'd3, 0, 34, 32'd3, 32'd0, 1'b0);

    // Reset at cycle 20 of an operation.
    snap = done_cnt;
    div_if.start_i = 1'b1; div_if.dividend_i = 32'd100; div_if.divisor_i = 32'd7;
    @(negedge clk);
    div_if.start_i = 1'b0;
    repeat (19) @(negedge clk);
    rst = 1'b1;
    #1;
    check("mrst.busy", {31'd0, div_if.busy_o}, 32'd0);
    check("mrst.q",    div_if.quotient_o, 32'd0);
    check("mrst.r",    div_if.remainder_o, 32'd0);
    check("mrst.dz",   {31'd0, div_if.div_zero_o}, 32'd0);
    repeat (20) @(negedge clk);
    check("mrst.no_done", 32'(done_cnt), 32'(snap));
    rst = 1'b0;
    @(negedge clk);
    div_test("post_rst", 32'd1000, 32'd10, 0, 34, 32'd100, 32'd0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
